// File: rtl/ysyx_22050710_mem_arbiter.sv
// Shares one memory port between IFU fetch and LSU load/store: one transaction
// in flight, round-robin grant on contention, owner-routed single-cycle response.
module ysyx_22050710_mem_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ifu_valid,
    input  logic [AW-1:0]   i_ifu_addr,
    output logic            o_ifu_ready,
    output logic            o_ifu_rvalid,
    output logic [DW-1:0]   o_ifu_rdata,
    input  logic            i_lsu_valid,
    input  logic [AW-1:0]   i_lsu_addr,
    input  logic            i_lsu_wen,
    input  logic [DW-1:0]   i_lsu_wdata,
    input  logic [DW/8-1:0] i_lsu_wmask,
    output logic            o_lsu_ready,
    output logic            o_lsu_rvalid,
    output logic [DW-1:0]   o_lsu_rdata,
    output logic            o_mem_valid,
    input  logic            i_mem_ready,
    output logic [AW-1:0]   o_mem_addr,
    output logic            o_mem_wen,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_wmask,
    input  logic            i_mem_rvalid,
    input  logic [DW-1:0]   i_mem_rdata,
    output logic            o_busy,
    output logic            o_proto_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e            state_q;
    logic              owner_lsu_q;
    logic              last_lsu_q;
    logic              proto_err_q;
    logic [AW-1:0]     addr_q;
    logic              wen_q;
    logic [DW-1:0]     wdata_q;
    logic [DW/8-1:0]   wmask_q;
    logic              gnt_ifu, gnt_lsu;
    logic              resp_hit;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        gnt_ifu = 1'b0;
        gnt_lsu = 1'b0;
        if (state_q == IDLE && !i_rst) begin
            if (i_ifu_valid && i_lsu_valid) begin
                gnt_lsu = !last_lsu_q;
                gnt_ifu = last_lsu_q;
            end else begin
                gnt_lsu = i_lsu_valid;
                gnt_ifu = i_ifu_valid;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            owner_lsu_q <= 1'b0;
            last_lsu_q  <= 1'b0;
            proto_err_q <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_ifu || gnt_lsu) begin
                        addr_q      <= gnt_lsu ? i_lsu_addr : i_ifu_addr;
                        wen_q       <= gnt_lsu & i_lsu_wen;
                        wdata_q     <= gnt_lsu ? i_lsu_wdata : '0;
                        wmask_q     <= gnt_lsu ? i_lsu_wmask : '0;
                        owner_lsu_q <= gnt_lsu;
                        last_lsu_q  <= gnt_lsu;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    // A response before the request was taken is a bus protocol error.
                    if (i_mem_rvalid) proto_err_q <= 1'b1;
                    if (i_mem_ready)  state_q     <= RESP;
                end
                RESP: begin
                    if (i_mem_rvalid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_hit     = (state_q == RESP) && i_mem_rvalid && !i_rst;
    assign o_ifu_ready  = gnt_ifu;
    assign o_lsu_ready  = gnt_lsu;
    assign o_ifu_rvalid = resp_hit && !owner_lsu_q;
    assign o_lsu_rvalid = resp_hit && owner_lsu_q;
    assign o_ifu_rdata  = o_ifu_rvalid ? i_mem_rdata : '0;
    assign o_lsu_rdata  = o_lsu_rvalid ? i_mem_rdata : '0;
    assign o_mem_valid  = (state_q == REQ);
    assign o_mem_addr   = addr_q;
    assign o_mem_wen    = wen_q;
    assign o_mem_wdata  = wdata_q;
    assign o_mem_wmask  = wmask_q;
    assign o_busy       = (state_q != IDLE);
    assign o_proto_err  = proto_err_q;
endmodule
